rect_draw_scheduler: RTL and testbench

//   Shares one filled-rectangle generator among NUM_REQ command requesters.

---
 rtl/rect_draw_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_rect_draw_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_draw_scheduler.sv
// rect_draw_scheduler: round-robin sharing of one filled-rectangle generator
// among NUM_REQ command requesters. Latches the winning command, pulses the
// generator start, forwards tagged coordinates and reports completion.
// Optional macro RECT_PIXEL_COUNT_EN adds a per-command pixel counter that
// drives cmd_err when the forwarded count differs from height*width.
module rect_draw_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int W       = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 _clock,
    input  logic                 _reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_s_x,
    input  logic [NUM_REQ*W-1:0] req_s_y,
    input  logic [NUM_REQ*W-1:0] req_height,
    input  logic [NUM_REQ*W-1:0] req_width,
    output logic                 gen_start,
    output logic [W-1:0]         gen_s_x,
    output logic [W-1:0]         gen_s_y,
    output logic [W-1:0]         gen_height,
    output logic [W-1:0]         gen_width,
    input  logic                 gen_valid,
    input  logic [W-1:0]         gen_out0,
    input  logic [W-1:0]         gen_out1,
    input  logic                 gen_done,
    output logic                 pix_valid,
    output logic [W-1:0]         pix_x,
    output logic [W-1:0]         pix_y,
    output logic [ID_W-1:0]      pix_id,
    output logic                 busy,
    output logic                 cmd_done,
    output logic [ID_W-1:0]      cmd_done_id,
    output logic                 cmd_err
);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_t;

    state_t          state, state_nx;
    logic [ID_W-1:0] last_gnt, gnt, id_q;
    logic            any_valid, accept, sel_degen;
    logic [W-1:0]    sel_sx, sel_sy, sel_h, sel_w;

    // Round-robin pick: lowest valid index above the last grant, else lowest
    // valid index at or below it (the second loop overrides the first).
    always_comb begin
        gnt       = last_gnt;
        any_valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && ID_W'(i) <= last_gnt) begin
                gnt       = ID_W'(i);
                any_valid = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && ID_W'(i) > last_gnt) begin
                gnt       = ID_W'(i);
                any_valid = 1'b1;
            end
        end
    end

    // Select the granted requester's command slot.
    always_comb begin
        sel_sx = '0;
        sel_sy = '0;
        sel_h  = '0;
        sel_w  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == gnt) begin
                sel_sx = req_s_x[i*W +: W];
                sel_sy = req_s_y[i*W +: W];
                sel_h  = req_height[i*W +: W];
                sel_w  = req_width[i*W +: W];
            end
        end
        sel_degen = ($signed(sel_h) <= 0) || ($signed(sel_w) <= 0);
    end

    assign accept = (state == IDLE) && any_valid;

    // Next-state and control outputs.
    always_comb begin
        state_nx    = state;
        req_ready   = '0;
        gen_start   = 1'b0;
        cmd_done    = 1'b0;
        cmd_done_id = '0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (any_valid) begin
                    // Gated by reset so nothing is offered while held in reset.
                    if (_reset_n) req_ready = NUM_REQ'(1) << gnt;
                    state_nx = sel_degen ? FINISH : LAUNCH;
                end
            end
            LAUNCH: begin
                gen_start = 1'b1;
                state_nx  = RUN;
            end
            RUN: begin
                if (gen_done) state_nx = FINISH;
            end
            FINISH: begin
                cmd_done    = 1'b1;
                cmd_done_id = id_q;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) state <= IDLE;
        else           state <= state_nx;
    end

    // Command latch and grant pointer; command stays stable until back in IDLE.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            gen_s_x    <= '0;
            gen_s_y    <= '0;
            gen_height <= '0;
            gen_width  <= '0;
            id_q       <= '0;
            last_gnt   <= ID_W'(NUM_REQ - 1);
        end else begin
            if (accept) begin
                gen_s_x    <= sel_sx;
                gen_s_y    <= sel_sy;
                gen_height <= sel_h;
                gen_width  <= sel_w;
                id_q       <= gnt;
            end
            if (state == FINISH) last_gnt <= id_q;
        end
    end

    // Pixel forwarding; a gen_valid alongside gen_done is still forwarded.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_id    <= '0;
        end else begin
            pix_valid <= (state == RUN) && gen_valid;
            if ((state == RUN) && gen_valid) begin
                pix_x  <= gen_out0;
                pix_y  <= gen_out1;
                pix_id <= id_q;
            end
        end
    end

`ifdef RECT_PIXEL_COUNT_EN
    localparam int W2 = 2 * W;
    logic [W2-1:0]        pix_cnt;
    logic signed [W2-1:0] exp_cnt;

    // Count pixels forwarded for the current command.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n)                          pix_cnt <= '0;
        else if (accept)                        pix_cnt <= '0;
        else if ((state == RUN) && gen_valid)   pix_cnt <= pix_cnt + 1'b1;
    end

    // Expected count: signed area, zero for degenerate commands.
    always_comb begin
        exp_cnt = W2'($signed(gen_height)) * W2'($signed(gen_width));
        if (($signed(gen_height) <= 0) || ($signed(gen_width) <= 0)) exp_cnt = '0;
    end

    assign cmd_err = (state == FINISH) && (pix_cnt != $unsigned(exp_cnt));
`else
    assign cmd_err = 1'b0;
`endif

endmodule

// File: tb/tb_rect_draw_scheduler.sv
// Directed bench for rect_draw_scheduler with a behavioural raster generator.
module tb_rect_draw_scheduler;
    localparam int NR = 2;
    localparam int W  = 32;
`ifdef RECT_PIXEL_COUNT_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0, req_ready;
    logic [NR*W-1:0] req_s_x = '0, req_s_y = '0, req_height = '0, req_width = '0;
    logic            gen_start, gen_valid, gen_done;
    logic [W-1:0]    gen_s_x, gen_s_y, gen_height, gen_width, gen_out0, gen_out1;
    logic            pix_valid, busy, cmd_done, cmd_err;
    logic [W-1:0]    pix_x, pix_y;
    logic            pix_id, cmd_done_id;

    rect_draw_scheduler #(.NUM_REQ(NR), .W(W), .ID_W(1)) dut (
        ._clock(clk), ._reset_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_s_x(req_s_x), .req_s_y(req_s_y), .req_height(req_height), .req_width(req_width),
        .gen_start(gen_start), .gen_s_x(gen_s_x), .gen_s_y(gen_s_y),
        .gen_height(gen_height), .gen_width(gen_width),
        .gen_valid(gen_valid), .gen_out0(gen_out0), .gen_out1(gen_out1), .gen_done(gen_done),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_id(pix_id),
        .busy(busy), .cmd_done(cmd_done), .cmd_done_id(cmd_done_id), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    initial forever begin @(posedge clk); cyc = cyc + 1; end

    // generator model controls / observations
    int gen_limit = -1;
    bit gen_co = 1'b0;
    int gfirst_cyc, gdone_cyc;

    // monitor observations
    int pcnt, dones, starts, id_bad, start_cyc, done_cyc, pfirst_cyc;
    int first_x, first_y, last_x, last_y;
    logic cur_id, done_id, done_err;

    // Raster generator: x inner, y outer; optionally short or done-with-last.
    initial begin
        int gk, gn, gx, gy, gw;
        bit gact;
        gen_valid = 0; gen_done = 0; gen_out0 = '0; gen_out1 = '0; gact = 0;
        gk = 0; gn = 0; gx = 0; gy = 0; gw = 1;
        forever begin
            @(negedge clk);
            gen_valid = 0; gen_done = 0;
            if (!rst_n) gact = 0;
            else if (gact) begin
                if (gk < gn) begin
                    gen_valid = 1;
                    gen_out0 = W'(gx + gk % gw);
                    gen_out1 = W'(gy + gk / gw);
                    if (gk == 0) gfirst_cyc = cyc;
                    gk++;
                    if (gk == gn && gen_co) begin gen_done = 1; gdone_cyc = cyc; gact = 0; end
                end else begin
                    gen_done = 1; gdone_cyc = cyc; gact = 0;
                end
            end else if (gen_start) begin
                gact = 1; gk = 0;
                gx = int'(gen_s_x); gy = int'(gen_s_y); gw = int'(gen_width);
                gn = (gen_limit >= 0) ? gen_limit : int'(gen_height) * int'(gen_width);
            end
        end
    end

    // Output monitor sampling on the falling edge.
    initial forever begin
        @(negedge clk);
        if (pix_valid) begin
            pcnt++;
            if (pcnt == 1) begin first_x = int'(pix_x); first_y = int'(pix_y); pfirst_cyc = cyc; end
            last_x = int'(pix_x); last_y = int'(pix_y);
            if (pix_id !== cur_id) id_bad++;
        end
        if (gen_start) begin starts++; start_cyc = cyc; end
        if (cmd_done) begin dones++; done_id = cmd_done_id; done_err = cmd_err; done_cyc = cyc; end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic clr();
        pcnt = 0; dones = 0; starts = 0; id_bad = 0;
    endtask

    task automatic set_cmd(input int sx, input int sy, input int h, input int w);
        for (int i = 0; i < NR; i++) begin
            req_s_x[i*W +: W] = W'(sx + 100 * i);
            req_s_y[i*W +: W] = W'(sy + 100 * i);
            req_height[i*W +: W] = W'(h);
            req_width[i*W +: W]  = W'(w);
        end
    endtask

    typedef struct {
        logic [1:0] valid;
        int sx, sy, h, w;
        int lim;
        bit co;
        logic [1:0] exp_ready;
        int exp_pix;
        bit exp_err;
    } vec_t;

    task automatic wait_done();
        for (int n = 0; n < 300; n++) begin
            if (dones > 0) break;
            tick();
        end
    endtask

    // Apply one command vector and check grant, latency, pixels and completion.
    task automatic run_vec(input vec_t v);
        int acc, osx, osy;
        tick();
        gen_limit = v.lim; gen_co = v.co;
        set_cmd(v.sx, v.sy, v.h, v.w);
        req_valid = v.valid;
        cur_id = v.exp_ready[1];
        clr();
        #1;
        chk("req_ready", req_ready, v.exp_ready);
        acc = cyc;
        tick();
        req_valid = '0;
        wait_done();
        osx = v.sx + 100 * int'(cur_id);
        osy = v.sy + 100 * int'(cur_id);
        chk("done_count", dones, 1);
        chk("done_id", done_id, cur_id);
        chk("cmd_err", done_err, v.exp_err);
        chk("pix_count", pcnt, v.exp_pix);
        chk("pix_id", id_bad, 0);
        chk("start_count", starts, (v.exp_pix > 0) ? 1 : 0);
        if (v.exp_pix > 0) begin
            chk("start_lat", start_cyc, acc + 1);
            chk("done_lat", done_cyc, gdone_cyc + 1);
            chk("pix_lat", pfirst_cyc, gfirst_cyc + 1);
            chk("first_x", first_x, osx);
            chk("first_y", first_y, osy);
            if (v.exp_pix == v.h * v.w) begin
                chk("last_x", last_x, osx + v.w - 1);
                chk("last_y", last_y, osy + v.h - 1);
            end
        end else begin
            chk("degen_done_lat", done_cyc, acc + 1);
        end
        gen_limit = -1; gen_co = 0;
    endtask

    vec_t tbl[11];

    initial begin
        int bad;
        tbl[0]  = '{2'b11, 23, 17, 5, 7, -1, 0, 2'b01, 35, 0};
        tbl[1]  = '{2'b11, 3, 4, 2, 3, -1, 0, 2'b10, 6, 0};
        tbl[2]  = '{2'b11, 5, 5, 1, 1, -1, 0, 2'b01, 1, 0};
        tbl[3]  = '{2'b11, 1, 1, 4, 0, -1, 0, 2'b10, 0, 0};
        tbl[4]  = '{2'b01, 1, 1, -1, 4, -1, 0, 2'b01, 0, 0};
        tbl[5]  = '{2'b01, 7, 8, 3, 2, -1, 0, 2'b01, 6, 0};
        tbl[6]  = '{2'b10, 0, 0, 2, 2, -1, 0, 2'b10, 4, 0};
        tbl[7]  = '{2'b01, 23, 17, 5, 7, 34, 0, 2'b01, 34, ERR_ON};
        tbl[8]  = '{2'b10, 2, 3, 2, 3, -1, 1, 2'b10, 6, 0};
        tbl[9]  = '{2'b11, 9, 9, 4, 1, -1, 0, 2'b01, 4, 0};
        tbl[10] = '{2'b10, 1, 1, -2, -3, -1, 0, 2'b10, 0, 0};
        cur_id = 0; done_id = 0; done_err = 0;
        clr();

        // reset state
        repeat (3) tick();
        chk("reset_outs", |{req_ready, gen_start, gen_s_x, gen_s_y, gen_height, gen_width,
                            pix_valid, pix_x, pix_y, pix_id, cmd_done, cmd_done_id, cmd_err}, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(tbl[i]);

        // req0 held valid across a busy period (pointer now at 1)
        tick();
        set_cmd(1, 2, 2, 2);
        req_valid = 2'b01; cur_id = 0; clr();
        #1;
        chk("hold_first_ready", req_ready, 2'b01);
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (dones > 0) break;
            if (!busy || req_ready != 0) bad++;
        end
        chk("hold_ready_low", bad, 0);
        chk("hold_pix", pcnt, 4);
        tick();
        clr();
        chk("hold_reaccept", req_ready, 2'b01);
        tick();
        req_valid = '0;
        wait_done();
        chk("hold_done_id", done_id, 0);
        chk("hold_pix2", pcnt, 4);

        // reset in the middle of a command
        tick();
        set_cmd(0, 0, 5, 7);
        req_valid = 2'b10; cur_id = 1; clr();
        tick();
        req_valid = '0;
        for (int n = 0; n < 100; n++) begin
            if (pcnt >= 10) break;
            tick();
        end
        chk("midreset_pix", pcnt, 10);
        rst_n = 1'b0;
        #1;
        chk("midreset_outs", |{req_ready, gen_start, gen_s_x, gen_s_y, gen_height, gen_width,
                               pix_valid, pix_x, pix_y, pix_id, cmd_done, cmd_done_id, cmd_err}, 0);
        chk("midreset_busy", busy, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        clr();
        repeat (5) tick();
        chk("postreset_starts", starts, 0);
        chk("postreset_dones", dones, 0);
        run_vec('{2'b01, 0, 0, 2, 2, -1, 0, 2'b01, 4, 0});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
